uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud ticks per bit; SHALL be an even value of at least 4.
REQ-002 clk_i  in  1  system clock, all logic on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 rx_i  in  1  serial line, asynchronous to clk_i, idle high.
REQ-005 ov_baud_tick_i  in  1  one-cycle pulse at OVERSAMPLE x baud rate.
REQ-006 data_width_i  in  2  data_width_e: DW_5BIT=0, DW_6BIT=1, DW_7BIT=2, DW_8BIT=3.
REQ-007 parity_mode_i  in  2  parity_mode_e: EVEN=0, ODD=1, DISABLED=2 or 3.
REQ-008 stop_bits_i  in  1  stop_bits_e: SB_1BIT=0, SB_2BIT=1.
REQ-009 rx_fifo_full_i  in  1  RX FIFO full.
REQ-010 data_rx_o  out  8  received data, right-aligned, unused upper bits 0.
REQ-011 parity_o  out  1  received parity bit, 0 when parity disabled.
REQ-012 frame_error_o  out  1  stop bit sampled low in the delivered frame.
REQ-013 overrun_o  out  1  one-cycle pulse when a frame is dropped because the FIFO is full.
REQ-014 rx_fifo_write_o  out  1  one-cycle write strobe for data_rx_o, parity_o and frame_error_o.
REQ-015 rx_busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 rx_i SHALL pass through a 2-FF synchronizer that resets to 1; all sampling uses the synchronized value.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, DONE; a 4-bit tick counter advances only on ov_baud_tick_i.
REQ-018 IDLE: a synchronized 0 SHALL move to START, clear the tick counter and latch data_width_i, parity_mode_i and stop_bits_i; configuration changes mid-frame have no effect.
REQ-019 START: on tick number OVERSAMPLE/2, a sampled 1 SHALL return the FSM to IDLE (glitch, no output); a sampled 0 SHALL move to DATA and clear the counter.
REQ-020 DATA: bits SHALL be sampled every OVERSAMPLE ticks, LSB first, into a shift register; after data_width+5 bits the FSM goes to PARITY if parity is enabled, else to STOP.
REQ-021 PARITY: one bit SHALL be sampled after OVERSAMPLE ticks and stored for parity_o; no checking is done in this block, the main controller checks parity.
REQ-022 STOP: bits SHALL be sampled after OVERSAMPLE ticks; any stop sample of 0 sets the frame error flag; with SB_2BIT a second stop sample is taken OVERSAMPLE ticks later.
REQ-023 The FSM SHALL move to DONE in the cycle after the last stop sample; DONE lasts exactly one clk_i cycle, then IDLE.
REQ-024 In DONE with rx_fifo_full_i=0: rx_fifo_write_o=1, and data_rx_o, parity_o and frame_error_o are valid in that same cycle.
REQ-025 In DONE with rx_fifo_full_i=1: rx_fifo_write_o=0, overrun_o=1 for one cycle, and the frame is discarded.
REQ-026 data_rx_o, parity_o and frame_error_o SHALL hold their values until the next DONE.
REQ-027 Back-to-back frames: a start bit seen in the IDLE cycle directly after DONE SHALL be accepted.
REQ-028 A line held low (break) SHALL produce a frame with data 0 and frame_error_o=1; the FSM then stays in IDLE until the line has returned high and fallen again.

Reset
REQ-029 On rst_i=1 the FSM goes to IDLE, counters and the shift register clear, the synchronizer resets to 1, and every output is 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no write and no overrun pulse.

Structure
REQ-031 data_width_e, parity_mode_e, stop_bits_e and the rx FSM state enum SHALL live in UART_pkg.
REQ-032 The synchronizer SHALL be a separate sub-module named sync_2ff, reused by the TX path; everything else is flat.

Verification
REQ-033 8N1 frame 0xA5, OVERSAMPLE=16 -> one write strobe, data_rx_o=0xA5, frame_error_o=0, strobe 1 cycle after the stop sample.
REQ-034 5-bit, EVEN parity, 2 stop bits, data 0x13 with parity bit 1 -> data_rx_o=0x13, parity_o=1, frame_error_o=0.
REQ-035 Low pulse of 6 ticks on idle line -> no write, FSM back in IDLE, rx_busy_o low.
REQ-036 8N1 0x3C with stop bit forced 0 -> data_rx_o=0x3C, frame_error_o=1.
REQ-037 rx_fifo_full_i=1 during DONE for frame 0x55 -> rx_fifo_write_o=0, single overrun_o pulse; next frame 0x66 with FIFO not full is written normally.
REQ-038 rst_i pulsed during data bit 4, then frame 0x81 -> no output for the aborted frame, 0x81 received correctly.

Source files
------------

// File: rtl/UART_pkg.sv
// Shared UART types: frame configuration encodings and the receive FSM states.
// Imported by the RX path here and intended to be shared with the TX path.
package UART_pkg;

   typedef enum logic [1:0] {
      DW_5BIT = 2'd0,
      DW_6BIT = 2'd1,
      DW_7BIT = 2'd2,
      DW_8BIT = 2'd3
   } data_width_e;

   typedef enum logic [1:0] {
      EVEN         = 2'd0,
      ODD          = 2'd1,
      DISABLED     = 2'd2,
      DISABLED_ALT = 2'd3
   } parity_mode_e;

   typedef enum logic {
      SB_1BIT = 1'b0,
      SB_2BIT = 1'b1
   } stop_bits_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_e;

   localparam int TICK_CNT_W = 4;

   function automatic logic parity_enabled(parity_mode_e mode);
      return (mode == EVEN) || (mode == ODD);
   endfunction

   // Index of the final data bit: 4 for 5-bit frames up to 7 for 8-bit frames.
   function automatic logic [2:0] last_bit_index(data_width_e dw);
      return 3'(dw) + 3'd4;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; reset value is
// configurable so an idle-high serial line reads as idle straight out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta <= RESET_VAL;
         q_o  <= RESET_VAL;
      end else begin
         meta <= d_i;
         q_o  <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit validation, 5..8 data bits LSB first,
// optional parity capture, 1 or 2 stop bits, one-cycle FIFO write or overrun.
module uart_receiver
   import UART_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       ov_baud_tick_i,
   input  logic [1:0] data_width_i,
   input  logic [1:0] parity_mode_i,
   input  logic       stop_bits_i,
   input  logic       rx_fifo_full_i,
   output logic [7:0] data_rx_o,
   output logic       parity_o,
   output logic       frame_error_o,
   output logic       overrun_o,
   output logic       rx_fifo_write_o,
   output logic       rx_busy_o
);

   localparam logic [TICK_CNT_W-1:0] HALF_LAST = TICK_CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_CNT_W-1:0] FULL_LAST = TICK_CNT_W'(OVERSAMPLE - 1);

   rx_state_e              state;
   rx_state_e              next_state;
   logic                   rx_sync;
   logic [TICK_CNT_W-1:0]  tick_cnt;
   logic [2:0]             bit_idx;
   logic                   stop_idx;
   logic [7:0]             shift_reg;
   logic                   parity_bit;
   logic                   frame_err;
   logic                   line_armed;
   data_width_e            cfg_dw;
   parity_mode_e           cfg_par;
   stop_bits_e             cfg_sb;
   logic                   sample_mid;
   logic                   sample_full;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (rx_i),
      .q_o   (rx_sync)
   );

   assign sample_mid  = ov_baud_tick_i && (tick_cnt == HALF_LAST);
   assign sample_full = ov_baud_tick_i && (tick_cnt == FULL_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A start is only accepted once the line has been seen high, so a held
   // break delivers one frame and then waits for a fresh falling edge.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!rx_sync && line_armed) next_state = START;
         START:   if (sample_mid) next_state = rx_sync ? IDLE : DATA;
         DATA:    if (sample_full && (bit_idx == last_bit_index(cfg_dw)))
                     next_state = parity_enabled(cfg_par) ? PARITY : STOP;
         PARITY:  if (sample_full) next_state = STOP;
         STOP:    if (sample_full && ((cfg_sb == SB_1BIT) || stop_idx)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      rx_fifo_write_o = 1'b0;
      overrun_o       = 1'b0;
      rx_busy_o       = (state != IDLE);
      if (state == DONE) begin
         rx_fifo_write_o = !rx_fifo_full_i;
         overrun_o       = rx_fifo_full_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_cnt      <= '0;
         bit_idx       <= '0;
         stop_idx      <= 1'b0;
         shift_reg     <= '0;
         parity_bit    <= 1'b0;
         frame_err     <= 1'b0;
         line_armed    <= 1'b0;
         cfg_dw        <= DW_8BIT;
         cfg_par       <= DISABLED;
         cfg_sb        <= SB_1BIT;
         data_rx_o     <= '0;
         parity_o      <= 1'b0;
         frame_error_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_sync) line_armed <= 1'b1;
               if (next_state == START) begin
                  tick_cnt   <= '0;
                  bit_idx    <= '0;
                  stop_idx   <= 1'b0;
                  shift_reg  <= '0;
                  parity_bit <= 1'b0;
                  frame_err  <= 1'b0;
                  cfg_dw     <= data_width_e'(data_width_i);
                  cfg_par    <= parity_mode_e'(parity_mode_i);
                  cfg_sb     <= stop_bits_e'(stop_bits_i);
               end
            end
            START: begin
               if (ov_baud_tick_i) tick_cnt <= sample_mid ? '0 : tick_cnt + 1'b1;
            end
            DATA: begin
               if (sample_full) begin
                  tick_cnt           <= '0;
                  shift_reg[bit_idx] <= rx_sync;
                  bit_idx            <= bit_idx + 3'd1;
               end else if (ov_baud_tick_i) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (sample_full) begin
                  tick_cnt   <= '0;
                  parity_bit <= rx_sync;
               end else if (ov_baud_tick_i) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            STOP: begin
               if (sample_full) begin
                  tick_cnt   <= '0;
                  stop_idx   <= 1'b1;
                  line_armed <= rx_sync;
                  if (!rx_sync) frame_err <= 1'b1;
               end else if (ov_baud_tick_i) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            default: ;
         endcase

         // Results are published on entry to DONE; the current stop sample is
         // folded in directly since frame_err has not been updated yet.
         if ((state == STOP) && (next_state == DONE)) begin
            data_rx_o     <= shift_reg;
            parity_o      <= parity_bit;
            frame_error_o <= frame_err | !rx_sync;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames with literal results
// plus randomized frames scored against a frame-level model.
module tb_uart_receiver;

   localparam int OS       = 16;
   localparam int TICK_DIV = 3;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       fe;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       tick;
   logic       full;
   logic [1:0] dw;
   logic [1:0] pm;
   logic       sb;
   logic [7:0] data_rx;
   logic       parity;
   logic       ferr;
   logic       overrun;
   logic       wr;
   logic       busy;

   int   n_cmp = 0;
   int   n_fail = 0;
   logic stop_window = 1'b0;
   exp_t exp_q[$];

   uart_receiver #(.OVERSAMPLE(OS)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rx_i            (rx),
      .ov_baud_tick_i  (tick),
      .data_width_i    (dw),
      .parity_mode_i   (pm),
      .stop_bits_i     (sb),
      .rx_fifo_full_i  (full),
      .data_rx_o       (data_rx),
      .parity_o        (parity),
      .frame_error_o   (ferr),
      .overrun_o       (overrun),
      .rx_fifo_write_o (wr),
      .rx_busy_o       (busy)
   );

   always #5 clk = ~clk;

   initial begin : tick_gen
      int div;
      div  = 0;
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick = (div == 0);
         div  = (div + 1) % TICK_DIV;
      end
   end

   function automatic exp_t mk(logic [7:0] d, logic p, logic fe, logic ov);
      exp_t e;
      e.d  = d;
      e.p  = p;
      e.fe = fe;
      e.ov = ov;
      return e;
   endfunction

   // What a frame must deliver, from the line-level description of that frame.
   function automatic exp_t model(logic [1:0] fdw, logic [1:0] fpm, logic fsb, logic [7:0] d,
                                  logic pbit, logic s1, logic s2, logic ffull);
      exp_t e;
      int   nb;
      nb   = int'(fdw) + 5;
      e.d  = d & 8'((1 << nb) - 1);
      e.p  = (fpm < 2) ? pbit : 1'b0;
      e.fe = !s1 || (fsb && !s2);
      e.ov = ffull;
      return e;
   endfunction

   task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && (wr === 1'b1 || overrun === 1'b1)) begin
         check_output("strobe_in_stop_window", 32'(stop_window), 32'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_frame: got wr=%0b ov=%0b data=0x%0h, required no frame",
                     wr, overrun, data_rx);
         end else begin
            e = exp_q.pop_front();
            check_output("overrun", 32'(overrun), 32'(e.ov));
            check_output("write", 32'(wr), 32'(!e.ov));
            if (!e.ov) begin
               check_output("data", 32'(data_rx), 32'(e.d));
               check_output("parity", 32'(parity), 32'(e.p));
               check_output("frame_error", 32'(ferr), 32'(e.fe));
            end
         end
      end
   end

   task automatic wait_ticks(int n);
      repeat (n) begin
         do @(posedge clk); while (tick !== 1'b1);
      end
      #2;
   endtask

   task automatic check_reset_outputs();
      check_output("rst_data", 32'(data_rx), 32'd0);
      check_output("rst_parity", 32'(parity), 32'd0);
      check_output("rst_ferr", 32'(ferr), 32'd0);
      check_output("rst_overrun", 32'(overrun), 32'd0);
      check_output("rst_write", 32'(wr), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
   endtask

   // Drives one frame; config inputs are scrambled mid-frame to show they are latched.
   task automatic apply_stimulus(input logic [1:0] fdw, input logic [1:0] fpm, input logic fsb,
                                 input logic [7:0] d, input logic pbit, input logic s1,
                                 input logic s2, input logic ffull, input int idle_ticks,
                                 input int abort_bit);
      int nb;
      nb   = int'(fdw) + 5;
      dw   = fdw;
      pm   = fpm;
      sb   = fsb;
      full = ffull;
      rx   = 1'b0;
      wait_ticks(4);
      dw = 2'($urandom);
      pm = 2'($urandom);
      sb = 1'($urandom);
      wait_ticks(OS - 4);
      for (int i = 0; i < nb; i++) begin
         rx = d[i];
         if (i == abort_bit) begin
            wait_ticks(OS / 2);
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs();
            @(posedge clk);
            #2;
            rst = 1'b0;
            rx  = 1'b1;
            return;
         end
         wait_ticks(OS);
      end
      if (fpm < 2) begin
         rx = pbit;
         wait_ticks(OS);
      end
      if (fsb) begin
         rx = s1;
         wait_ticks(OS);
         rx = s2;
      end else begin
         rx = s1;
      end
      wait_ticks(OS / 2 - 2);
      stop_window = 1'b1;
      wait_ticks(OS / 2 + 2);
      stop_window = 1'b0;
      rx = 1'b1;
      if (idle_ticks > 0) wait_ticks(idle_ticks);
   endtask

   initial begin : main
      logic [1:0] fdw, fpm;
      logic       fsb, pbit, s1, s2, ffull, last_ok;
      logic [7:0] d;
      int         idle, budget;

      rst  = 1'b1;
      rx   = 1'b1;
      full = 1'b0;
      dw   = 2'd3;
      pm   = 2'd2;
      sb   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_ticks(20);

      exp_q.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
      apply_stimulus(2'd3, 2'd2, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1);

      exp_q.push_back(mk(8'h13, 1'b1, 1'b0, 1'b0));
      apply_stimulus(2'd0, 2'd0, 1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 1'b0, 4, -1);

      rx = 1'b0;
      wait_ticks(3);
      check_output("glitch_busy", 32'(busy), 32'd1);
      wait_ticks(3);
      rx = 1'b1;
      wait_ticks(12);
      check_output("glitch_idle", 32'(busy), 32'd0);
      check_output("glitch_pending", 32'(exp_q.size()), 32'd0);

      exp_q.push_back(mk(8'h3C, 1'b0, 1'b1, 1'b0));
      apply_stimulus(2'd3, 2'd2, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 6, -1);

      exp_q.push_back(mk(8'h55, 1'b0, 1'b0, 1'b1));
      apply_stimulus(2'd3, 2'd2, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 4, -1);
      exp_q.push_back(mk(8'h66, 1'b0, 1'b0, 1'b0));
      apply_stimulus(2'd3, 2'd2, 1'b0, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1);

      apply_stimulus(2'd3, 2'd2, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4);
      wait_ticks(20);
      exp_q.push_back(mk(8'h81, 1'b0, 1'b0, 1'b0));
      apply_stimulus(2'd3, 2'd2, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1);

      // Break: one all-zero frame with a framing error, then silence while low.
      dw = 2'd3;
      pm = 2'd2;
      sb = 1'b0;
      exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0));
      rx = 1'b0;
      stop_window = 1'b1;
      wait_ticks(OS * 20);
      stop_window = 1'b0;
      check_output("break_idle_while_low", 32'(busy), 32'd0);
      check_output("break_single_frame", 32'(exp_q.size()), 32'd0);
      rx = 1'b1;
      wait_ticks(2 * OS);
      exp_q.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0));
      apply_stimulus(2'd3, 2'd2, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1);

      for (int n = 0; n < 30; n++) begin
         fdw     = 2'($urandom);
         fpm     = 2'($urandom);
         fsb     = 1'($urandom);
         d       = 8'($urandom);
         pbit    = 1'($urandom);
         s1      = ($urandom_range(0, 7) != 0);
         s2      = ($urandom_range(0, 7) != 0);
         ffull   = ($urandom_range(0, 5) == 0);
         last_ok = fsb ? s2 : s1;
         idle    = last_ok ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
         exp_q.push_back(model(fdw, fpm, fsb, d, pbit, s1, s2, ffull));
         apply_stimulus(fdw, fpm, fsb, d, pbit, s1, s2, ffull, idle, -1);
      end
      full = 1'b0;

      budget = 0;
      while (exp_q.size() != 0 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      check_output("pending_frames", 32'(exp_q.size()), 32'd0);
      wait_ticks(4);
      check_output("final_idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
